// File: rtl/cpu_pkg.sv
// Shared types and constants for the Datapath2 hardwired control unit.
package cpu_pkg;

    localparam int unsigned OPW   = 5;
    localparam int unsigned STEPW = 4;

    typedef enum logic [STEPW-1:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Instruction opcodes (IR[31:27])
    localparam logic [OPW-1:0] OPC_LD   = 5'd0;
    localparam logic [OPW-1:0] OPC_LDI  = 5'd1;
    localparam logic [OPW-1:0] OPC_ST   = 5'd2;
    localparam logic [OPW-1:0] OPC_ADD  = 5'd3;
    localparam logic [OPW-1:0] OPC_SUB  = 5'd4;
    localparam logic [OPW-1:0] OPC_AND  = 5'd5;
    localparam logic [OPW-1:0] OPC_OR   = 5'd6;
    localparam logic [OPW-1:0] OPC_SHR  = 5'd7;
    localparam logic [OPW-1:0] OPC_SHRA = 5'd8;
    localparam logic [OPW-1:0] OPC_SHL  = 5'd9;
    localparam logic [OPW-1:0] OPC_ROR  = 5'd10;
    localparam logic [OPW-1:0] OPC_ROL  = 5'd11;
    localparam logic [OPW-1:0] OPC_ADDI = 5'd12;
    localparam logic [OPW-1:0] OPC_ANDI = 5'd13;
    localparam logic [OPW-1:0] OPC_ORI  = 5'd14;
    localparam logic [OPW-1:0] OPC_MUL  = 5'd15;
    localparam logic [OPW-1:0] OPC_DIV  = 5'd16;
    localparam logic [OPW-1:0] OPC_NEG  = 5'd17;
    localparam logic [OPW-1:0] OPC_NOT  = 5'd18;
    localparam logic [OPW-1:0] OPC_BR   = 5'd19;
    localparam logic [OPW-1:0] OPC_JR   = 5'd20;
    localparam logic [OPW-1:0] OPC_JAL  = 5'd21;
    localparam logic [OPW-1:0] OPC_IN   = 5'd22;
    localparam logic [OPW-1:0] OPC_OUT  = 5'd23;
    localparam logic [OPW-1:0] OPC_MFHI = 5'd24;
    localparam logic [OPW-1:0] OPC_MFLO = 5'd25;
    localparam logic [OPW-1:0] OPC_NOP  = 5'd26;
    localparam logic [OPW-1:0] OPC_HALT = 5'd27;

    // ALU control codes used outside the R-type path
    localparam logic [OPW-1:0] OP_ADD   = 5'd3;
    localparam logic [OPW-1:0] OP_INCPC = 5'd12;

    // Full strobe set driven into the datapath
    typedef struct packed {
        logic [OPW-1:0] alu_op;
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic outport_in;
        logic con_in;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic r15_sel;
        logic run;
    } ctrl_t;

    // Final execute step of each opcode; the step after it is T0
    function automatic state_t last_step(input logic [OPW-1:0] op);
        state_t s;
        case (op)
            OPC_LD, OPC_ST:                 s = S_T7;
            OPC_MUL, OPC_DIV, OPC_BR:       s = S_T6;
            OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA,
            OPC_SHL, OPC_ROR, OPC_ROL, OPC_ADDI, OPC_ANDI, OPC_ORI:
                                            s = S_T5;
            OPC_NEG, OPC_NOT, OPC_JAL:      s = S_T4;
            default:                        s = S_T3;
        endcase
        return s;
    endfunction

    // Sequential successor within the execute phase
    function automatic state_t step_after(input state_t s);
        state_t n;
        case (s)
            S_T3:    n = S_T4;
            S_T4:    n = S_T5;
            S_T5:    n = S_T6;
            S_T6:    n = S_T7;
            default: n = S_T0;
        endcase
        return n;
    endfunction

    // Execute steps that hold until memory reports done
    function automatic logic mem_wait_step(input state_t s, input logic [OPW-1:0] op);
        return ((s == S_T6) && (op == OPC_LD)) || ((s == S_T7) && (op == OPC_ST));
    endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational strobe decode from the current step, latched opcode and branch flag.
module cs_decode
    import cpu_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] op_q,
    input  logic           con_ff,
    output ctrl_t          ctrl
);

    // Strobes for the current step; anything not named stays low
    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.z_in = 1'b1;
                ctrl.alu_op = OP_INCPC;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            S_T3: begin
                case (op_q)
                    OPC_LD, OPC_LDI, OPC_ST: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA, OPC_SHL,
                    OPC_ROR, OPC_ROL, OPC_ADDI, OPC_ANDI, OPC_ORI: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    OPC_NEG, OPC_NOT: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = op_q;
                    end
                    OPC_MUL, OPC_DIV: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    OPC_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                    OPC_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    OPC_JAL:  begin ctrl.pc_out = 1'b1; ctrl.r15_sel = 1'b1; ctrl.r_in = 1'b1; end
                    OPC_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OPC_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                    OPC_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OPC_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_q)
                    OPC_LD, OPC_LDI, OPC_ST: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = OP_ADD;
                    end
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA, OPC_SHL,
                    OPC_ROR, OPC_ROL: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = op_q;
                    end
                    OPC_ADDI, OPC_ANDI, OPC_ORI: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = op_q;
                    end
                    OPC_NEG, OPC_NOT: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    OPC_MUL, OPC_DIV: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = op_q;
                    end
                    OPC_BR:  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                    OPC_JAL: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_q)
                    OPC_LD, OPC_ST: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
                    OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA, OPC_SHL,
                    OPC_ROR, OPC_ROL, OPC_ADDI, OPC_ANDI, OPC_ORI: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    OPC_MUL, OPC_DIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                    OPC_BR: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = OP_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_q)
                    OPC_LD:  begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                    OPC_ST:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
                    OPC_MUL, OPC_DIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                    OPC_BR:  begin ctrl.zlow_out = con_ff; ctrl.pc_in = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_q)
                    OPC_LD:  begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OPC_ST:  ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T7 control sequencer for the Datapath2 RISC datapath.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic [OPW-1:0] ir_op,
    input  logic           con_ff,
    input  logic           mem_rdy,
    output logic [OPW-1:0] alu_op,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           InportOut,
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           OutportIn,
    output logic           CONin,
    output logic           Read,
    output logic           Write,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Cout,
    output logic           r15_sel,
    output logic           run
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    logic           stall_c;
    ctrl_t          dec_ctrl;
    ctrl_t          ctrl_c;

    // Step register; clr returns to RST immediately
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_RST;
        else      state_q <= state_d;
    end

    // Opcode captured as fetch hands over to execute
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                                      op_q <= '0;
        else if ((state_q == S_T2) && (state_d == S_T3)) op_q <= ir_op;
    end

    assign stall_c = mem_wait_step(state_q, op_q) && !mem_rdy;

    // Next step: fetch, opcode dispatch at T2, execute with memory waits
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_rdy) state_d = S_T2;
            S_T2: begin
                if (ir_op == OPC_HALT)     state_d = S_HALT;
                else if (ir_op >= OPC_NOP) state_d = S_T0;
                else                       state_d = S_T3;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                if (stall_c)                          state_d = state_q;
                else if (state_q == last_step(op_q))  state_d = S_T0;
                else                                  state_d = step_after(state_q);
            end
        endcase
    end

    cs_decode u_decode (
        .state  (state_q),
        .op_q   (op_q),
        .con_ff (con_ff),
        .ctrl   (dec_ctrl)
    );

    // PC load during fetch waits for the memory-done cycle
    always_comb begin
        ctrl_c = dec_ctrl;
        if ((state_q == S_T1) && !mem_rdy) ctrl_c.pc_in = 1'b0;
    end

    assign alu_op    = ctrl_c.alu_op;
    assign PCout     = ctrl_c.pc_out;
    assign Zhighout  = ctrl_c.zhigh_out;
    assign Zlowout   = ctrl_c.zlow_out;
    assign MDRout    = ctrl_c.mdr_out;
    assign HIout     = ctrl_c.hi_out;
    assign LOout     = ctrl_c.lo_out;
    assign InportOut = ctrl_c.inport_out;
    assign MARin     = ctrl_c.mar_in;
    assign Zin       = ctrl_c.z_in;
    assign PCin      = ctrl_c.pc_in;
    assign MDRin     = ctrl_c.mdr_in;
    assign IRin      = ctrl_c.ir_in;
    assign Yin       = ctrl_c.y_in;
    assign HIin      = ctrl_c.hi_in;
    assign LOin      = ctrl_c.lo_in;
    assign OutportIn = ctrl_c.outport_in;
    assign CONin     = ctrl_c.con_in;
    assign Read      = ctrl_c.read;
    assign Write     = ctrl_c.write;
    assign Gra       = ctrl_c.gra;
    assign Grb       = ctrl_c.grb;
    assign Grc       = ctrl_c.grc;
    assign Rin       = ctrl_c.r_in;
    assign Rout      = ctrl_c.r_out;
    assign BAout     = ctrl_c.ba_out;
    assign Cout      = ctrl_c.c_out;
    assign r15_sel   = ctrl_c.r15_sel;
    assign run       = ctrl_c.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction step tables feed an expected-vector queue.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int K_PLAIN = 0;
    localparam int K_WAIT  = 1;
    localparam int K_FETCH = 2;
    localparam int K_BR    = 3;

    typedef struct {
        ctrl_t c;
        int    kind;
    } step_t;

    logic           clk;
    logic           clr;
    logic [OPW-1:0] ir_op;
    logic           con_ff;
    logic           mem_rdy;
    logic [OPW-1:0] alu_op;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InportOut;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutportIn, CONin;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, r15_sel, run;

    ctrl_t act;
    assign act = {alu_op, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InportOut,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutportIn, CONin,
                  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, r15_sel, run};

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir_op(ir_op), .con_ff(con_ff), .mem_rdy(mem_rdy),
        .alu_op(alu_op), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .InportOut(InportOut),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .OutportIn(OutportIn), .CONin(CONin),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Cout(Cout), .r15_sel(r15_sel), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t exp_q[$];
    int    tag_q[$];
    step_t plan[$];
    int    checks   = 0;
    int    failures = 0;
    int    cf_force   = -1;
    int    wait_force = -1;
    logic  probe_req  = 1'b0;
    logic  done_req   = 1'b0;

    function automatic ctrl_t blank();
        ctrl_t c = '0;
        c.run = 1'b1;
        return c;
    endfunction

    function automatic void add_step(input ctrl_t c, input int kind);
        step_t s;
        s.c = c;
        s.kind = kind;
        plan.push_back(s);
    endfunction

    function automatic void push_exp(input ctrl_t e, input int t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endfunction

    // Reference step list for one instruction, straight from the instruction table
    function automatic void build_plan(input logic [OPW-1:0] op);
        ctrl_t c;
        plan.delete();
        c = blank(); c.pc_out = 1; c.mar_in = 1; c.z_in = 1; c.alu_op = OP_INCPC; add_step(c, K_PLAIN);
        c = blank(); c.zlow_out = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1;        add_step(c, K_FETCH);
        c = blank(); c.mdr_out = 1; c.ir_in = 1;                                   add_step(c, K_PLAIN);
        if (op inside {OPC_LD, OPC_LDI, OPC_ST}) begin
            c = blank(); c.grb = 1; c.ba_out = 1; c.y_in = 1;             add_step(c, K_PLAIN);
            c = blank(); c.c_out = 1; c.z_in = 1; c.alu_op = OP_ADD;     add_step(c, K_PLAIN);
            c = blank(); c.zlow_out = 1;
            if (op == OPC_LDI) begin
                c.gra = 1; c.r_in = 1; add_step(c, K_PLAIN);
            end else begin
                c.mar_in = 1; add_step(c, K_PLAIN);
                if (op == OPC_LD) begin
                    c = blank(); c.read = 1; c.mdr_in = 1;             add_step(c, K_WAIT);
                    c = blank(); c.mdr_out = 1; c.gra = 1; c.r_in = 1; add_step(c, K_PLAIN);
                end else begin
                    c = blank(); c.gra = 1; c.r_out = 1; c.mdr_in = 1; add_step(c, K_PLAIN);
                    c = blank(); c.write = 1;                          add_step(c, K_WAIT);
                end
            end
        end else if (op >= OPC_ADD && op <= OPC_ORI) begin
            c = blank(); c.grb = 1; c.r_out = 1; c.y_in = 1; add_step(c, K_PLAIN);
            c = blank();
            if (op <= OPC_ROL) begin c.grc = 1; c.r_out = 1; end
            else c.c_out = 1;
            c.z_in = 1; c.alu_op = op; add_step(c, K_PLAIN);
            c = blank(); c.zlow_out = 1; c.gra = 1; c.r_in = 1; add_step(c, K_PLAIN);
        end else if (op inside {OPC_NEG, OPC_NOT}) begin
            c = blank(); c.grb = 1; c.r_out = 1; c.z_in = 1; c.alu_op = op; add_step(c, K_PLAIN);
            c = blank(); c.zlow_out = 1; c.gra = 1; c.r_in = 1;            add_step(c, K_PLAIN);
        end else if (op inside {OPC_MUL, OPC_DIV}) begin
            c = blank(); c.gra = 1; c.r_out = 1; c.y_in = 1;               add_step(c, K_PLAIN);
            c = blank(); c.grb = 1; c.r_out = 1; c.z_in = 1; c.alu_op = op; add_step(c, K_PLAIN);
            c = blank(); c.zlow_out = 1; c.lo_in = 1;                      add_step(c, K_PLAIN);
            c = blank(); c.zhigh_out = 1; c.hi_in = 1;                     add_step(c, K_PLAIN);
        end else if (op == OPC_BR) begin
            c = blank(); c.gra = 1; c.r_out = 1; c.con_in = 1;           add_step(c, K_PLAIN);
            c = blank(); c.pc_out = 1; c.y_in = 1;                       add_step(c, K_PLAIN);
            c = blank(); c.c_out = 1; c.z_in = 1; c.alu_op = OP_ADD;     add_step(c, K_PLAIN);
            c = blank();                                                 add_step(c, K_BR);
        end else if (op == OPC_JR) begin
            c = blank(); c.gra = 1; c.r_out = 1; c.pc_in = 1;            add_step(c, K_PLAIN);
        end else if (op == OPC_JAL) begin
            c = blank(); c.pc_out = 1; c.r15_sel = 1; c.r_in = 1;        add_step(c, K_PLAIN);
            c = blank(); c.gra = 1; c.r_out = 1; c.pc_in = 1;            add_step(c, K_PLAIN);
        end else if (op == OPC_IN) begin
            c = blank(); c.inport_out = 1; c.gra = 1; c.r_in = 1;        add_step(c, K_PLAIN);
        end else if (op == OPC_OUT) begin
            c = blank(); c.gra = 1; c.r_out = 1; c.outport_in = 1;       add_step(c, K_PLAIN);
        end else if (op == OPC_MFHI) begin
            c = blank(); c.hi_out = 1; c.gra = 1; c.r_in = 1;            add_step(c, K_PLAIN);
        end else if (op == OPC_MFLO) begin
            c = blank(); c.lo_out = 1; c.gra = 1; c.r_in = 1;            add_step(c, K_PLAIN);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ir_op carries the instruction through fetch, then is scrambled so only the latched copy matters
    task automatic drive(input logic [OPW-1:0] op, input int idx, input logic rdy);
        mem_rdy = rdy;
        con_ff  = (cf_force >= 0) ? (cf_force != 0) : 1'($urandom_range(0, 1));
        ir_op   = (idx < 3) ? op : OPW'($urandom);
    endtask

    task automatic do_reset(input int n);
        for (int j = 0; j < n; j++) begin
            tick(); clr = 1'b0; drive(5'd0, 9, 1'($urandom_range(0, 1)));
            push_exp('0, 999);
        end
        tick(); clr = 1'b1; drive(5'd0, 9, 1'($urandom_range(0, 1)));
        push_exp('0, 998);
    endtask

    task automatic run_instr(input logic [OPW-1:0] op, input int stop_step);
        ctrl_t e;
        int    k;
        int    kind;
        build_plan(op);
        for (int i = 0; i < plan.size(); i++) begin
            kind = plan[i].kind;
            if (i == stop_step) begin
                tick(); drive(op, i, 1'b0);
                push_exp(plan[i].c, int'(op) * 16 + i);
                probe_req = 1'b1;
                @(negedge clk);
                #2 clr = 1'b0;
                probe_req = 1'b0;
                return;
            end
            k = 0;
            if (kind == K_WAIT || kind == K_FETCH)
                k = (kind == K_WAIT && wait_force >= 0) ? wait_force : int'($urandom_range(0, 2));
            for (int j = 0; j <= k; j++) begin
                tick();
                if (kind == K_WAIT || kind == K_FETCH) drive(op, i, (j == k));
                else                                   drive(op, i, 1'($urandom_range(0, 1)));
                e = plan[i].c;
                if (kind == K_FETCH && !mem_rdy) e.pc_in = 1'b0;
                if (kind == K_BR && con_ff) begin e.zlow_out = 1'b1; e.pc_in = 1'b1; end
                push_exp(e, int'(op) * 16 + i);
            end
        end
        if (op == OPC_HALT) begin
            repeat (20) begin
                tick(); drive(op, 9, 1'($urandom_range(0, 1)));
                push_exp('0, int'(op) * 16 + 9);
            end
        end
    endtask

    // Monitor: pops one expected vector per cycle, plus the async-clear probe and end-of-run drain
    initial begin : monitor
        ctrl_t e;
        int    t;
        int    nsrc;
        bit    done_seen;
        done_seen = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL ctrl tag=%0d op=%0d step=%0d actual=%h required=%h", t, t / 16, t % 16, act, e);
                end
                nsrc = int'(PCout) + int'(Zhighout) + int'(Zlowout) + int'(MDRout) + int'(HIout)
                     + int'(LOout) + int'(InportOut) + int'(Rout) + int'(BAout) + int'(Cout);
                checks++;
                if (nsrc > 1) begin
                    failures++;
                    $display("FAIL bus_sources tag=%0d actual=%0d required<=1", t, nsrc);
                end
            end
            if (probe_req) begin
                #3;
                checks++;
                if (act !== '0) begin
                    failures++;
                    $display("FAIL async_clr actual=%h Write=%b required=0", act, Write);
                end
            end
            if (done_req && !done_seen) begin
                done_seen = 1;
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL drain actual=%0d required=0", exp_q.size());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : driver
        logic [OPW-1:0] op;
        clr = 1'b0; ir_op = '0; con_ff = 1'b0; mem_rdy = 1'b0;

        do_reset(3);

        cf_force = 0; run_instr(OPC_BR, -1);
        cf_force = 1; run_instr(OPC_BR, -1);
        cf_force = -1;

        wait_force = 4; run_instr(OPC_LD, -1);
        wait_force = -1;

        for (int n = 0; n < 200; n++) begin
            op = OPW'($urandom_range(0, 31));
            if (op == OPC_HALT) op = OPC_NOP;
            run_instr(op, -1);
        end

        run_instr(OPC_ADD, -1);
        run_instr(OPC_HALT, -1);

        do_reset(2);
        run_instr(OPC_ST, 7);

        do_reset(2);
        for (int n = 0; n < 20; n++) begin
            op = OPW'($urandom_range(0, 26));
            run_instr(op, -1);
        end

        tick();
        done_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
